hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
- Generates stall, flush and operand-forwarding selects for the fetch, decode and execute registers.
- Sequences multi-cycle data-memory waits with a timeout watchdog and keeps saturating stall/flush event counters.
- Sits beside the decode stage: consumes its source-register addresses and the E/M/W destination info, and drives its enable/clear hazard inputs.

Parameters:
- MEM_TIMEOUT, 64, max consecutive data-memory wait cycles before the error state (>=1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- RS1_D_i  in  5  decode-stage source address 1
- RS2_D_i  in  5  decode-stage source address 2
- RS1_E_i  in  5  execute-stage source address 1
- RS2_E_i  in  5  execute-stage source address 2
- RD_E_i  in  5  execute-stage destination address
- RSLTSRC_E_i  in  2  execute-stage result source; 2'b01 = load
- REGWRT_E_i  in  1  execute-stage register write enable
- RD_M_i  in  5  memory-stage destination address
- REGWRT_M_i  in  1  memory-stage register write enable
- RD_W_i  in  5  writeback-stage destination address
- REGWRT_W_i  in  1  writeback-stage register write enable
- PCSRC_E_i  in  1  taken branch or jump resolved in E
- MEM_REQ_M_i  in  1  data-memory access active in M
- MEM_RDY_M_i  in  1  data memory ready
- STALL_F_o  out  1  hold PC
- STALL_D_o  out  1  hold F/D register
- STALL_EM_o  out  1  hold D/E and E/M registers
- FLUSH_D_o  out  1  clear F/D register
- FLUSH_E_o  out  1  clear D/E register (bubble)
- FWD_A_E_o  out  2  forward select, ALU operand A
- FWD_B_E_o  out  2  forward select, ALU operand B
- ERR_o  out  1  sticky memory-timeout error
- STALL_CNT_o  out  CNT_W  cycles with STALL_F_o high
- FLUSH_CNT_o  out  CNT_W  cycles with FLUSH_D_o high

Interface decision: reset rst_i, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset: FSM enters RUN; both counters and ERR_o are 0.
  - Combinational outputs evaluate from inputs.
  - With all inputs 0, every output is 0.
- Forwarding, operand A (B is identical using RS2_E_i):
  - 2'b10 if REGWRT_M_i, RD_M_i!=0 and RD_M_i==RS1_E_i.
  - Else 2'b01 if REGWRT_W_i, RD_W_i!=0 and RD_W_i==RS1_E_i.
  - Else 2'b00. The M stage has priority over W.
- mem_wait = MEM_REQ_M_i & ~MEM_RDY_M_i.
- Load-use hazard: RSLTSRC_E_i==2'b01, RD_E_i!=0, and RD_E_i matches RS1_D_i or RS2_D_i.
- Outputs in RUN, combinational, same cycle:
  - If mem_wait: STALL_F_o, STALL_D_o and STALL_EM_o are 1; FLUSH_D_o and FLUSH_E_o are 0. Flushes are suppressed so frozen instructions are not killed; a pending PCSRC_E_i flushes on the release cycle.
  - Else if PCSRC_E_i: FLUSH_D_o and FLUSH_E_o are 1, no stall. Redirect wins over load-use.
  - Else if load-use: STALL_F_o, STALL_D_o and FLUSH_E_o are 1 for exactly one cycle.
  - Else all stall and flush outputs are 0.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when mem_wait is 1; the wait counter loads 1.
  - MEM_WAIT: outputs are the same as the RUN mem_wait case; the counter increments each cycle mem_wait is still 1.
  - MEM_WAIT -> RUN when MEM_RDY_M_i is 1 (release cycle; normal RUN decode applies that cycle) or when MEM_REQ_M_i drops.
  - MEM_WAIT -> ERROR when the counter reaches MEM_TIMEOUT and the memory is still not ready.
  - ERROR: ERR_o=1; STALL_F_o, STALL_D_o and STALL_EM_o are held at 1; flushes are 0. ERROR is left only by reset.
- Counters: registered, increment after each cycle the source signal is high, saturate at all-ones.
- Reset asserted mid-wait: immediately returns to RUN and clears ERR_o and all counters.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: forwarding behaves as above.
- Undefined:
  - FWD_A_E_o and FWD_B_E_o are tied to 2'b00.
  - Any RAW match of RS1_D_i or RS2_D_i (non-zero) against an E, M or W destination with its write enable set causes STALL_F_o, STALL_D_o and FLUSH_E_o, repeated until the hazard clears.
  - The load-use rule is subsumed by this stall.

Decomposition:
- Package hazard_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT, ERROR);
  - forward selects FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RSLT_LOAD=2'b01.
- One natural sub-module, hazard_fwd_sel: the per-operand forward-select compare, instantiated twice.

Test Plan:
1. add x5 in M, RS1_E_i=5, REGWRT_M_i=1; also RD_W_i=5 with REGWRT_W_i=1 -> FWD_A_E_o=2'b10; with RD_M_i=0 -> FWD_A_E_o=2'b01.
2. Load with RD_E_i=7, RSLTSRC_E_i=01; RS2_D_i=7 -> STALL_F_o, STALL_D_o and FLUSH_E_o are 1 for one cycle; STALL_CNT_o=1.
3. Load-use together with PCSRC_E_i=1 -> FLUSH_D_o and FLUSH_E_o are 1; STALL_F_o=0; FLUSH_CNT_o=1.
4. MEM_REQ_M_i=1 and MEM_RDY_M_i low for 3 cycles, PCSRC_E_i=1 throughout -> stalls for 3 cycles with no flush; flush on the release cycle; STALL_CNT_o=3.
5. MEM_TIMEOUT=4, MEM_RDY_M_i held low -> ERR_o rises once the count reaches 4; stalls stay high; rst_i pulse -> all outputs 0.
6. HAZARD_FWD_EN undefined, RS1_D_i=3 matches RD_M_i=3 with REGWRT_M_i=1 -> stall and bubble; FWD outputs stay 2'b00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t   FWD_NONE  = 2'b00;
    localparam fwd_sel_t   FWD_W     = 2'b01;
    localparam fwd_sel_t   FWD_M     = 2'b10;
    localparam logic [1:0] RSLT_LOAD = 2'b01;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic raw_hit(input logic [4:0] rs, input logic [4:0] rd, input logic wen);
        return wen && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard controller; master = pipeline, slave = controller.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RS1_D_i;
    logic [4:0]       RS2_D_i;
    logic [4:0]       RS1_E_i;
    logic [4:0]       RS2_E_i;
    logic [4:0]       RD_E_i;
    logic [1:0]       RSLTSRC_E_i;
    logic             REGWRT_E_i;
    logic [4:0]       RD_M_i;
    logic             REGWRT_M_i;
    logic [4:0]       RD_W_i;
    logic             REGWRT_W_i;
    logic             PCSRC_E_i;
    logic             MEM_REQ_M_i;
    logic             MEM_RDY_M_i;
    logic             STALL_F_o;
    logic             STALL_D_o;
    logic             STALL_EM_o;
    logic             FLUSH_D_o;
    logic             FLUSH_E_o;
    logic [1:0]       FWD_A_E_o;
    logic [1:0]       FWD_B_E_o;
    logic             ERR_o;
    logic [CNT_W-1:0] STALL_CNT_o;
    logic [CNT_W-1:0] FLUSH_CNT_o;

    modport master (
        output RS1_D_i, RS2_D_i, RS1_E_i, RS2_E_i, RD_E_i, RSLTSRC_E_i, REGWRT_E_i,
               RD_M_i, REGWRT_M_i, RD_W_i, REGWRT_W_i, PCSRC_E_i, MEM_REQ_M_i, MEM_RDY_M_i,
        input  STALL_F_o, STALL_D_o, STALL_EM_o, FLUSH_D_o, FLUSH_E_o,
               FWD_A_E_o, FWD_B_E_o, ERR_o, STALL_CNT_o, FLUSH_CNT_o
    );

    modport slave (
        input  RS1_D_i, RS2_D_i, RS1_E_i, RS2_E_i, RD_E_i, RSLTSRC_E_i, REGWRT_E_i,
               RD_M_i, REGWRT_M_i, RD_W_i, REGWRT_W_i, PCSRC_E_i, MEM_REQ_M_i, MEM_RDY_M_i,
        output STALL_F_o, STALL_D_o, STALL_EM_o, FLUSH_D_o, FLUSH_E_o,
               FWD_A_E_o, FWD_B_E_o, ERR_o, STALL_CNT_o, FLUSH_CNT_o
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward select for one ALU operand; the M-stage result is newer than W, so it wins.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       regwrt_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrt_w_i,
    output fwd_sel_t   fwd_o
);

    always_comb begin
        fwd_o = FWD_NONE;
        if (raw_hit(rs_i, rd_m_i, regwrt_m_i)) begin
            fwd_o = FWD_M;
        end else if (raw_hit(rs_i, rd_w_i, regwrt_w_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward control for the 5-stage core with a data-memory wait watchdog.
// Build macro HAZARD_FWD_EN enables E-stage forwarding; without it every RAW hazard stalls decode.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_ctrl_unit_if.slave hz
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic     mem_wait, load_use, data_hz;
    logic     stall_f, stall_d, stall_em, flush_d, flush_e;
    fwd_sel_t fwd_a, fwd_b;

    assign mem_wait = hz.MEM_REQ_M_i & ~hz.MEM_RDY_M_i;
    assign load_use = (hz.RSLTSRC_E_i == RSLT_LOAD) &&
                      (raw_hit(hz.RS1_D_i, hz.RD_E_i, 1'b1) || raw_hit(hz.RS2_D_i, hz.RD_E_i, 1'b1));

`ifdef HAZARD_FWD_EN
    hazard_fwd_sel u_fwd_a (
        .rs_i       (hz.RS1_E_i),
        .rd_m_i     (hz.RD_M_i),
        .regwrt_m_i (hz.REGWRT_M_i),
        .rd_w_i     (hz.RD_W_i),
        .regwrt_w_i (hz.REGWRT_W_i),
        .fwd_o      (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i       (hz.RS2_E_i),
        .rd_m_i     (hz.RD_M_i),
        .regwrt_m_i (hz.REGWRT_M_i),
        .rd_w_i     (hz.RD_W_i),
        .regwrt_w_i (hz.REGWRT_W_i),
        .fwd_o      (fwd_b)
    );

    assign data_hz = load_use;
`else
    logic unused_e_srcs;

    assign fwd_a         = FWD_NONE;
    assign fwd_b         = FWD_NONE;
    assign unused_e_srcs = ^{hz.RS1_E_i, hz.RS2_E_i};
    // Without bypassing, decode holds until every in-flight writer of its sources has retired.
    assign data_hz = load_use
        | raw_hit(hz.RS1_D_i, hz.RD_E_i, hz.REGWRT_E_i) | raw_hit(hz.RS2_D_i, hz.RD_E_i, hz.REGWRT_E_i)
        | raw_hit(hz.RS1_D_i, hz.RD_M_i, hz.REGWRT_M_i) | raw_hit(hz.RS2_D_i, hz.RD_M_i, hz.REGWRT_M_i)
        | raw_hit(hz.RS1_D_i, hz.RD_W_i, hz.REGWRT_W_i) | raw_hit(hz.RS2_D_i, hz.RD_W_i, hz.REGWRT_W_i);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // wcnt_q holds the number of consecutive wait cycles already seen.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = ERROR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // The release cycle of a wait falls through to the normal decode, so a held redirect flushes then.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (state_q == ERROR || mem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
        end else if (hz.PCSRC_E_i) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (data_hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_d && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign hz.STALL_F_o   = stall_f;
    assign hz.STALL_D_o   = stall_d;
    assign hz.STALL_EM_o  = stall_em;
    assign hz.FLUSH_D_o   = flush_d;
    assign hz.FLUSH_E_o   = flush_e;
    assign hz.FWD_A_E_o   = fwd_a;
    assign hz.FWD_B_E_o   = fwd_b;
    assign hz.ERR_o       = (state_q == ERROR);
    assign hz.STALL_CNT_o = stall_cnt_q;
    assign hz.FLUSH_CNT_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: vector table, directed wait/timeout sequences, random run against a model.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    hazard_ctrl_unit_if #(.CNT_W(CW)) hif();

    hazard_ctrl_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hif)
    );

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic [1:0] rslt_e;
        logic       we_e;
        logic [4:0] rd_m;
        logic       we_m;
        logic [4:0] rd_w;
        logic       we_w;
        logic       pcsrc, req, rdy;
    } in_t;

    typedef struct {
        logic       sf, sd, sem, fd, fe;
        logic [1:0] fa, fb;
    } out_t;

    // ctl = {STALL_F, STALL_D, STALL_EM, FLUSH_D, FLUSH_E}; _f with forwarding built in, _nf without.
    typedef struct {
        in_t        i;
        logic [4:0] ctl_f;
        logic [1:0] fa, fb;
        logic [4:0] ctl_nf;
    } vec_t;

    int  n_assert = 0;
    int  n_fail   = 0;
    in_t cur;
    in_t zero_in;
    bit  m_err;
    int  m_wait, m_scnt, m_fcnt;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    function automatic bit dep(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && rs != 5'd0 && rs == rd;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] rs, input in_t i);
        if (!FWD_ON) return 2'b00;
        if (dep(rs, i.rd_m, i.we_m)) return 2'b10;
        if (dep(rs, i.rd_w, i.we_w)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model(input in_t i, input bit err);
        out_t o;
        bit   lu, hzd;
        o  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        lu = i.rslt_e == 2'b01 && i.rd_e != 5'd0 && (i.rd_e == i.rs1_d || i.rd_e == i.rs2_d);
        hzd = lu;
        if (!FWD_ON)
            hzd = lu | dep(i.rs1_d, i.rd_e, i.we_e) | dep(i.rs1_d, i.rd_m, i.we_m) | dep(i.rs1_d, i.rd_w, i.we_w)
                     | dep(i.rs2_d, i.rd_e, i.we_e) | dep(i.rs2_d, i.rd_m, i.we_m) | dep(i.rs2_d, i.rd_w, i.we_w);
        o.fa = fsel(i.rs1_e, i);
        o.fb = fsel(i.rs2_e, i);
        if (err || (i.req && !i.rdy)) begin
            o.sf = 1'b1; o.sd = 1'b1; o.sem = 1'b1;
        end else if (i.pcsrc) begin
            o.fd = 1'b1; o.fe = 1'b1;
        end else if (hzd) begin
            o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
        end
        return o;
    endfunction

    function automatic logic [8:0] pk(input out_t o);
        return {o.sf, o.sd, o.sem, o.fd, o.fe, o.fa, o.fb};
    endfunction

    task automatic drive(input in_t i);
        cur             = i;
        hif.RS1_D_i     = i.rs1_d;
        hif.RS2_D_i     = i.rs2_d;
        hif.RS1_E_i     = i.rs1_e;
        hif.RS2_E_i     = i.rs2_e;
        hif.RD_E_i      = i.rd_e;
        hif.RSLTSRC_E_i = i.rslt_e;
        hif.REGWRT_E_i  = i.we_e;
        hif.RD_M_i      = i.rd_m;
        hif.REGWRT_M_i  = i.we_m;
        hif.RD_W_i      = i.rd_w;
        hif.REGWRT_W_i  = i.we_w;
        hif.PCSRC_E_i   = i.pcsrc;
        hif.MEM_REQ_M_i = i.req;
        hif.MEM_RDY_M_i = i.rdy;
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_out();
        return {hif.STALL_F_o, hif.STALL_D_o, hif.STALL_EM_o, hif.FLUSH_D_o, hif.FLUSH_E_o,
                hif.FWD_A_E_o, hif.FWD_B_E_o};
    endfunction

    task automatic chk_cnt(input string nm, input int s, input int f);
        chk({nm, "_stall_cnt"}, 32'(hif.STALL_CNT_o), 32'(s));
        chk({nm, "_flush_cnt"}, 32'(hif.FLUSH_CNT_o), 32'(f));
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_out"}, 32'(dut_out()), 32'(pk(model(cur, m_err))));
        chk({nm, "_err"}, 32'(hif.ERR_o), 32'(m_err));
        chk({nm, "_cnt"}, {hif.STALL_CNT_o, hif.FLUSH_CNT_o}, 32'(m_scnt * 16 + m_fcnt));
    endtask

    // Advance one clock; the model counts the cycle just presented.
    task automatic tick();
        out_t o;
        o = model(cur, m_err);
        if (o.sf && m_scnt < CMAX) m_scnt++;
        if (o.fd && m_fcnt < CMAX) m_fcnt++;
        if (!m_err) begin
            if (cur.req && !cur.rdy) begin
                if (m_wait == TO) m_err = 1'b1;
                m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        drive(zero_in);
        m_err = 1'b0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    vec_t tbl[16];
    in_t  lu_in, w_in, r_in;
    logic [8:0] exp9;

    initial begin
        zero_in = '{default: '0};
        //             rs1d rs2d rs1e rs2e rde  rslt we_e rdm  we_m rdw  we_w pc   req  rdy
        tbl[0]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'b00, 2'b00, 5'b00000};
        tbl[1]  = '{'{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b10, 2'b00, 5'b00000};
        tbl[2]  = '{'{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b01, 2'b00, 5'b00000};
        tbl[3]  = '{'{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b00, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b01, 5'b00000};
        tbl[4]  = '{'{5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 2'b00, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b10, 2'b10, 5'b00000};
        tbl[5]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b00, 5'b00000};
        tbl[6]  = '{'{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 5'b11001, 2'b00, 2'b00, 5'b11001};
        tbl[7]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b00, 5'b00000};
        tbl[8]  = '{'{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1}, 5'b00011, 2'b00, 2'b00, 5'b00011};
        tbl[9]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}, 5'b00011, 2'b00, 2'b00, 5'b00011};
        tbl[10] = '{'{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0}, 5'b11100, 2'b00, 2'b00, 5'b11100};
        tbl[11] = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1}, 5'b00011, 2'b00, 2'b00, 5'b00011};
        tbl[12] = '{'{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b00, 5'b11001};
        tbl[13] = '{'{5'd0, 5'd8, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b00, 5'b11001};
        tbl[14] = '{'{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}, 5'b00000, 2'b00, 2'b00, 5'b00000};
        tbl[15] = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'b00, 2'b00, 5'b00000};

        // Reset state with all inputs zero.
        drive(zero_in);
        chk("reset_out", 32'(dut_out()), 32'd0);
        chk("reset_err", 32'(hif.ERR_o), 32'd0);
        chk_cnt("reset", 0, 0);
        do_reset();

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].i);
            exp9 = FWD_ON ? {tbl[k].ctl_f, tbl[k].fa, tbl[k].fb} : {tbl[k].ctl_nf, 4'b0000};
            chk($sformatf("vec%0d", k), 32'(dut_out()), 32'(exp9));
            tick();
        end

        // Load-use: one stall cycle, bubble into E.
        do_reset();
        lu_in = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        drive(lu_in);
        chk("loaduse_out", 32'(dut_out()), 32'(9'b11001_0000));
        tick();
        drive(zero_in);
        chk_cnt("loaduse", 1, 0);

        // Redirect beats load-use.
        do_reset();
        lu_in.pcsrc = 1'b1;
        drive(lu_in);
        chk("redirect_out", 32'(dut_out()), 32'(9'b00011_0000));
        tick();
        drive(zero_in);
        chk_cnt("redirect", 0, 1);

        // Memory wait with a pending redirect: stall 3 cycles, flush on release.
        do_reset();
        w_in = '{default: '0};
        w_in.req = 1'b1; w_in.pcsrc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(w_in);
            chk($sformatf("wait%0d_out", k), 32'(dut_out()), 32'(9'b11100_0000));
            tick();
        end
        w_in.rdy = 1'b1;
        drive(w_in);
        chk("release_out", 32'(dut_out()), 32'(9'b00011_0000));
        tick();
        drive(zero_in);
        chk_cnt("release", 3, 1);

        // Timeout: ERR rises after TO+1 consecutive wait cycles and holds the stall.
        do_reset();
        w_in = '{default: '0};
        w_in.req = 1'b1;
        for (int k = 0; k <= TO; k++) begin
            drive(w_in);
            chk($sformatf("to%0d_err", k), 32'(hif.ERR_o), 32'd0);
            tick();
        end
        drive(w_in);
        chk("to_err_set", 32'(hif.ERR_o), 32'd1);
        w_in.rdy = 1'b1; w_in.pcsrc = 1'b1;
        drive(w_in);
        chk("to_err_hold_out", 32'(dut_out()), 32'(9'b11100_0000));
        tick();
        chk("to_err_sticky", 32'(hif.ERR_o), 32'd1);
        chk_cnt("to", TO + 2, 0);
        // Asynchronous reset in the middle of a cycle.
        w_in.rdy = 1'b0; w_in.pcsrc = 1'b0;
        drive(w_in);
        rst_i = 1'b0;
        #1;
        chk("arst_err", 32'(hif.ERR_o), 32'd0);
        chk_cnt("arst", 0, 0);
        drive(zero_in);
        chk("arst_out", 32'(dut_out()), 32'd0);
        rst_i = 1'b1;
        m_err = 1'b0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
        @(posedge clk_i);
        #1;

        // RAW on a decode source against M: stall without forwarding, forward otherwise.
        do_reset();
        r_in = '{default: '0};
        r_in.rs1_d = 5'd3; r_in.rs1_e = 5'd3; r_in.rd_m = 5'd3; r_in.we_m = 1'b1; r_in.rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(r_in);
            exp9 = FWD_ON ? 9'b00000_1000 : 9'b11001_0000;
            chk($sformatf("raw%0d_out", k), 32'(dut_out()), 32'(exp9));
            tick();
        end

        // Random traffic against the model, with periodic resets to leave ERROR.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_t ri;
            if (n % 150 == 149) do_reset();
            ri.rs1_d  = 5'($urandom_range(0, 3));
            ri.rs2_d  = 5'($urandom_range(0, 3));
            ri.rs1_e  = 5'($urandom_range(0, 3));
            ri.rs2_e  = 5'($urandom_range(0, 3));
            ri.rd_e   = 5'($urandom_range(0, 3));
            ri.rslt_e = 2'($urandom_range(0, 3));
            ri.we_e   = 1'($urandom);
            ri.rd_m   = 5'($urandom_range(0, 3));
            ri.we_m   = 1'($urandom);
            ri.rd_w   = 5'($urandom_range(0, 3));
            ri.we_w   = 1'($urandom);
            ri.pcsrc  = ($urandom_range(0, 3) == 0);
            ri.req    = ($urandom_range(0, 2) == 0);
            ri.rdy    = ($urandom_range(0, 3) != 0);
            if (n % 150 < 20) ri.rdy = 1'b0;
            drive(ri);
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
